// File: rtl/oet_sorter_pkg.sv
// rtl/oet_sorter_pkg.sv - shared types and default sizing for the odd-even transposition sorter
package oet_sorter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;
  localparam int CNT_W     = $clog2(DEF_DEPTH) + 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Plain-vector state encodings for registers that stay untyped
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_SORT  = SORT;
  localparam logic [1:0] ST_DRAIN = DRAIN;

endpackage

// File: rtl/oet_sorter_cmp_swap.sv
// rtl/oet_sorter_cmp_swap.sv - unsigned min/max compare-exchange cell
module cmp_swap #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swapped
);

  // Strict compare so equal words keep their order and report no swap
  always_comb begin
    swapped = (a > b);
    lo      = swapped ? b : a;
    hi      = swapped ? a : b;
  end

endmodule

// File: rtl/oet_sorter.sv
// rtl/oet_sorter.sv - frame sorter, one odd-even transposition pass per cycle; optional SORTER_EARLY_EXIT_EN
module oet_sorter
  import oet_sorter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam int            IW   = CW - 1;
  localparam int            NEV  = DEPTH / 2;
  localparam int            NOD  = (DEPTH > 2) ? (DEPTH / 2 - 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    pass_q;
  logic [WIDTH-1:0] word_q   [DEPTH];
  logic [WIDTH-1:0] sort_nxt [DEPTH];

  logic [WIDTH-1:0] ev_lo [NEV];
  logic [WIDTH-1:0] ev_hi [NEV];
  logic [NEV-1:0]   ev_sw;
  logic [WIDTH-1:0] od_lo [NOD];
  logic [WIDTH-1:0] od_hi [NOD];
  logic [NOD-1:0]   od_sw;
  logic             sort_done;

  // Even-pass cells on pairs (0,1),(2,3),...
  for (genvar i = 0; i < NEV; i++) begin : g_even
    cmp_swap #(.WIDTH(WIDTH)) u_cell (
      .a       (word_q[2*i]),
      .b       (word_q[2*i+1]),
      .lo      (ev_lo[i]),
      .hi      (ev_hi[i]),
      .swapped (ev_sw[i])
    );
  end

  // Odd-pass cells on pairs (1,2),(3,4),...; a 2-word frame has none
  if (DEPTH > 2) begin : g_odd
    for (genvar j = 0; j < DEPTH / 2 - 1; j++) begin : g_cell
      cmp_swap #(.WIDTH(WIDTH)) u_cell (
        .a       (word_q[2*j+1]),
        .b       (word_q[2*j+2]),
        .lo      (od_lo[j]),
        .hi      (od_hi[j]),
        .swapped (od_sw[j])
      );
    end
  end else begin : g_odd_none
    assign od_lo[0] = '0;
    assign od_hi[0] = '0;
    assign od_sw    = '0;
  end

  // Per-slot mux picking this pass's cell output; odd passes hold the two end slots
  for (genvar k = 0; k < DEPTH; k++) begin : g_nxt
    logic [WIDTH-1:0] ev_v;
    logic [WIDTH-1:0] od_v;
    if (k % 2 == 0) begin : g_ev_lo
      assign ev_v = ev_lo[k/2];
    end else begin : g_ev_hi
      assign ev_v = ev_hi[k/2];
    end
    if (k == 0 || k == DEPTH - 1) begin : g_od_hold
      assign od_v = word_q[k];
    end else if (k % 2 == 1) begin : g_od_lo
      assign od_v = od_lo[(k-1)/2];
    end else begin : g_od_hi
      assign od_v = od_hi[(k-2)/2];
    end
    assign sort_nxt[k] = pass_q[0] ? od_v : ev_v;
  end

`ifdef SORTER_EARLY_EXIT_EN
  logic quiet_q;
  logic any_sw;

  assign any_sw    = pass_q[0] ? (|od_sw) : (|ev_sw);
  // An even and an odd pass back to back with no swaps prove every adjacent pair ordered
  assign sort_done = (pass_q == LAST) || (quiet_q && !any_sw);

  // Remember whether the previous pass was swap-free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quiet_q <= 1'b0;
    end else if (state_q == ST_SORT) begin
      quiet_q <= !any_sw;
    end else begin
      quiet_q <= 1'b0;
    end
  end
`else
  logic unused_swaps;
  assign unused_swaps = ^{ev_sw, od_sw};
  assign sort_done    = (pass_q == LAST);
`endif

  // Frame FSM: load words, run passes, then shift the buffer out from slot 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      pass_q  <= '0;
      for (int k = 0; k < DEPTH; k++) word_q[k] <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            word_q[cnt_q[IW-1:0]] <= in_data;
            if (cnt_q == LAST) begin
              state_q <= ST_SORT;
              cnt_q   <= '0;
              pass_q  <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_SORT: begin
          for (int k = 0; k < DEPTH; k++) word_q[k] <= sort_nxt[k];
          pass_q <= pass_q + 1'b1;
          if (sort_done) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            for (int k = 0; k < DEPTH - 1; k++) word_q[k] <= word_q[k+1];
            word_q[DEPTH-1] <= '0;
            if (cnt_q == LAST) begin
              state_q <= ST_LOAD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_LOAD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_SORT);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = word_q[0];
  assign out_last  = (state_q == ST_DRAIN) && (cnt_q == LAST);

endmodule

// File: tb/tb_oet_sorter.sv
// tb/tb_oet_sorter.sv - self-checking bench for oet_sorter with a sorted-frame scoreboard
module tb_oet_sorter;

  localparam int W = 32;
  localparam int D = 8;

  typedef logic [W-1:0] frame_t [D];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb [$];

  oet_sorter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t ref_sort(input frame_t f);
    frame_t s;
    logic [W-1:0] t;
    s = f;
    for (int i = 1; i < D; i++) begin
      for (int j = i; j > 0; j--) begin
        if (s[j-1] > s[j]) begin
          t = s[j-1]; s[j-1] = s[j]; s[j] = t;
        end
      end
    end
    return s;
  endfunction

  // Feeds one frame, pushes its sorted image, optionally measures busy/latency
  task automatic send_frame(input frame_t f, input logic keep_valid, input logic measure,
                            output int lat, output int bcyc);
    frame_t s;
    int g;
    s = ref_sort(f);
    for (int i = 0; i < D; i++) sb.push_back(s[i]);
    for (int i = 0; i < D; i++) begin
      in_data  = f[i];
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 200) begin step(); g++; end
      if (g >= 200) chk("in_ready_timeout", 64'd0, 64'd1);
      step();
    end
    in_valid = keep_valid;
    in_data  = 32'hDEAD_BEEF;
    lat  = 0;
    bcyc = 0;
    if (measure) begin
      chk("in_ready_in_sort", {63'd0, in_ready}, 64'd0);
      while (!out_valid && lat < 100) begin
        if (busy) bcyc++;
        step();
        lat++;
      end
    end
  endtask

  // Drains one frame with out_ready following pat[0..3] cyclically
  task automatic drain(input logic [3:0] pat);
    int i, pi, g;
    i = 0; pi = 0; g = 0;
    while (i < D && g < 500) begin
      out_ready = pat[pi % 4];
      pi++;
      if (out_valid) begin
        chk("out_data", {32'd0, out_data}, {32'd0, sb[0]});
        chk("out_last", {63'd0, out_last}, {63'd0, (i == D - 1)});
        chk("in_ready_in_drain", {63'd0, in_ready}, 64'd0);
        if (out_ready) begin
          void'(sb.pop_front());
          i++;
        end
      end
      step();
      g++;
    end
    if (i < D) chk("drain_timeout", i, D);
    out_ready = 1'b0;
    chk("in_ready_after_last", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after_last", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    int lat, bc;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  {32'd0, out_data},  64'd0);
    chk("rst_out_last",  {63'd0, out_last},  64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);

    // Reverse order
    for (int i = 0; i < D; i++) f[i] = W'(D - 1 - i);
    send_frame(f, 1'b0, 1'b1, lat, bc);
`ifndef SORTER_EARLY_EXIT_EN
    chk("rev_latency", lat, D);
    chk("rev_busy_cycles", bc, D);
`endif
    drain(4'b1111);

    // Duplicates and all-ones word
    f[0] = 32'd5; f[1] = 32'd5; f[2] = 32'd0; f[3] = 32'hFFFF_FFFF;
    f[4] = 32'd5; f[5] = 32'd0; f[6] = 32'd1; f[7] = 32'd1;
    send_frame(f, 1'b0, 1'b1, lat, bc);
    drain(4'b1111);

    // Backpressure 1,0,0,1 repeating
    for (int i = 0; i < D; i++) f[i] = $urandom;
    send_frame(f, 1'b0, 1'b1, lat, bc);
    drain(4'b1001);

    // Reset during pass 3
    for (int i = 0; i < D; i++) f[i] = $urandom;
    send_frame(f, 1'b0, 1'b0, lat, bc);
    repeat (3) step();
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy",      {63'd0, busy},      64'd0);
    for (int i = 0; i < D; i++) f[i] = $urandom_range(0, 15);
    send_frame(f, 1'b0, 1'b1, lat, bc);
    drain(4'b1111);

    // Back-to-back with in_valid held high
    for (int i = 0; i < D; i++) f[i] = $urandom;
    send_frame(f, 1'b1, 1'b1, lat, bc);
    drain(4'b1111);
    for (int i = 0; i < D; i++) f[i] = $urandom;
    send_frame(f, 1'b1, 1'b1, lat, bc);
    drain(4'b1111);
    in_valid = 1'b0;

    // Already sorted input
    for (int i = 0; i < D; i++) f[i] = W'(i);
    send_frame(f, 1'b0, 1'b1, lat, bc);
`ifdef SORTER_EARLY_EXIT_EN
    chk("sorted_busy_cycles", bc, 2);
    chk("sorted_latency", lat, 2);
`else
    chk("sorted_busy_cycles", bc, D);
    chk("sorted_latency", lat, D);
`endif
    drain(4'b1111);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
